// File: rtl/pid_loop_sequencer.sv
// pid_loop_sequencer
//
// This block is the initiator side of the PID trig/done handshake.
// - It runs a free-running sample-period counter.
// - On each tick it captures one sensor sample into a held feedback register.
// - It then fires a single-cycle trig into the PID and waits for done.
// - When done arrives it clamps the PID result into a registered actuator command.
// A cycle that gets no done within TIMEOUT cycles is aborted and sets a sticky
// error flag. A tick that arrives while a cycle is still in flight sets the
// sticky overrun flag and is dropped.
//
// Optional feature (macro PID_SEQ_RATE_LIMIT_EN):
//   Adds the max_step_i input. The clamped command is also limited to
//   act_out_o +/- max_step_i, using saturating signed arithmetic.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   enable_i       loop run; low returns to idle and aborts any cycle in flight
//   period_i       sample period in clk cycles (0 is treated as 1)
//   fb_in_i        sensor sample, signed
//   fb_valid_i     fb_in_i is valid this cycle
//   feedback_o     held sample, driven to the PID
//   trig_o         one-cycle calculation request to the PID
//   done_i         PID result valid (pulse)
//   sig_in_i       PID result, signed
//   out_min_i      lower clamp limit, signed
//   out_max_i      upper clamp limit, signed
//   max_step_i     per-update step limit, unsigned (only with PID_SEQ_RATE_LIMIT_EN)
//   err_clr_i      clears both sticky flags (a same-cycle set wins)
//   act_out_o      registered actuator command
//   act_valid_o    one-cycle pulse when act_out_o is updated
//   overrun_o      sticky: a tick arrived while a cycle was in flight
//   timeout_err_o  sticky: done was not seen within TIMEOUT cycles

module pid_loop_sequencer #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic [PERIOD_WIDTH-1:0]      period_i,
  input  logic signed [DATA_WIDTH-1:0] fb_in_i,
  input  logic                         fb_valid_i,
  output logic signed [DATA_WIDTH-1:0] feedback_o,
  output logic                         trig_o,
  input  logic                         done_i,
  input  logic signed [DATA_WIDTH-1:0] sig_in_i,
  input  logic signed [DATA_WIDTH-1:0] out_min_i,
  input  logic signed [DATA_WIDTH-1:0] out_max_i,
`ifdef PID_SEQ_RATE_LIMIT_EN
  input  logic [DATA_WIDTH-1:0]        max_step_i,
`endif
  input  logic                         err_clr_i,
  output logic signed [DATA_WIDTH-1:0] act_out_o,
  output logic                         act_valid_o,
  output logic                         overrun_o,
  output logic                         timeout_err_o
);

  // Wide enough to hold the value TIMEOUT itself.
  localparam int unsigned ToW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitTick,
    StWaitSample,
    StTrig,
    StWaitDone
  } state_e;

  state_e                         state_q;
  logic [PERIOD_WIDTH-1:0]        per_cnt_q;
  logic [ToW-1:0]                 to_cnt_q;
  logic signed [DATA_WIDTH-1:0]   feedback_q;
  logic signed [DATA_WIDTH-1:0]   act_q;
  logic                           trig_q;
  logic                           act_valid_q;
  logic                           overrun_q;
  logic                           timeout_err_q;

  logic [PERIOD_WIDTH-1:0]        per_reload;
  logic                           tick;
  logic                           to_expired;
  logic signed [DATA_WIDTH-1:0]   clamp_val;
  logic signed [DATA_WIDTH-1:0]   cmd_val;

  // A period of 0 behaves as 1: the counter reloads to 0 and ticks every cycle.
  assign per_reload = (period_i == '0) ? '0 : (period_i - PERIOD_WIDTH'(1));

  assign tick = (state_q != StIdle) && (per_cnt_q == '0);

  // The counter is loaded with TIMEOUT on the first WAIT_DONE cycle. A value of 1
  // therefore marks the TIMEOUT-th cycle without done.
  assign to_expired = (to_cnt_q <= ToW'(1));

  // Signed clamp. Inverted limits resolve to out_min.
  always_comb begin
    clamp_val = sig_in_i;
    if (out_min_i > out_max_i) begin
      clamp_val = out_min_i;
    end else if (sig_in_i < out_min_i) begin
      clamp_val = out_min_i;
    end else if (sig_in_i > out_max_i) begin
      clamp_val = out_max_i;
    end
  end

`ifdef PID_SEQ_RATE_LIMIT_EN
  localparam int unsigned XW = DATA_WIDTH + 2;

  logic signed [XW-1:0] prev_x, step_x, tgt_x, hi_x, lo_x, hi_s, lo_s, pos_lim, neg_lim;

  // Work two bits wider so that prev +/- step cannot wrap, then saturate the
  // window to the representable range before comparing against the target.
  always_comb begin
    prev_x  = {{2{act_q[DATA_WIDTH-1]}}, act_q};
    tgt_x   = {{2{clamp_val[DATA_WIDTH-1]}}, clamp_val};
    step_x  = {2'b00, max_step_i};
    pos_lim = {3'b000, {(DATA_WIDTH - 1){1'b1}}};
    neg_lim = {3'b111, {(DATA_WIDTH - 1){1'b0}}};
    hi_x    = prev_x + step_x;
    lo_x    = prev_x - step_x;
    hi_s    = (hi_x > pos_lim) ? pos_lim : hi_x;
    lo_s    = (lo_x < neg_lim) ? neg_lim : lo_x;
    cmd_val = clamp_val;
    if (tgt_x > hi_s) begin
      cmd_val = hi_s[DATA_WIDTH-1:0];
    end else if (tgt_x < lo_s) begin
      cmd_val = lo_s[DATA_WIDTH-1:0];
    end
  end
`else
  assign cmd_val = clamp_val;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      per_cnt_q     <= '0;
      to_cnt_q      <= '0;
      feedback_q    <= '0;
      act_q         <= '0;
      trig_q        <= 1'b0;
      act_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      trig_q      <= 1'b0;
      act_valid_q <= 1'b0;

      // Clear first, so that a set later in this block takes priority.
      if (err_clr_i) begin
        overrun_q     <= 1'b0;
        timeout_err_q <= 1'b0;
      end

      if (!enable_i) begin
        state_q <= StIdle;
      end else begin
        if (state_q != StIdle) begin
          per_cnt_q <= tick ? per_reload : (per_cnt_q - PERIOD_WIDTH'(1));
        end

        unique case (state_q)
          StIdle: begin
            per_cnt_q <= per_reload;
            state_q   <= StWaitTick;
          end

          StWaitTick: begin
            if (tick) begin
              state_q <= StWaitSample;
            end
          end

          StWaitSample: begin
            if (tick) begin
              overrun_q <= 1'b1;
            end
            if (fb_valid_i) begin
              feedback_q <= fb_in_i;
              trig_q     <= 1'b1;
              state_q    <= StTrig;
            end
          end

          StTrig: begin
            if (tick) begin
              overrun_q <= 1'b1;
            end
            to_cnt_q <= ToW'(TIMEOUT);
            state_q  <= StWaitDone;
          end

          StWaitDone: begin
            if (tick) begin
              overrun_q <= 1'b1;
            end
            if (to_cnt_q != '0) begin
              to_cnt_q <= to_cnt_q - ToW'(1);
            end
            // If done arrives in the expiry cycle, it is accepted.
            if (done_i) begin
              act_q       <= cmd_val;
              act_valid_q <= 1'b1;
              state_q     <= StWaitTick;
            end else if (to_expired) begin
              timeout_err_q <= 1'b1;
              state_q       <= StWaitTick;
            end
          end

          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign feedback_o    = feedback_q;
  assign trig_o        = trig_q;
  assign act_out_o     = act_q;
  assign act_valid_o   = act_valid_q;
  assign overrun_o     = overrun_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Directed bench for pid_loop_sequencer. It contains a small PID responder and
// a trig/act_valid event log. When PID_SEQ_RATE_LIMIT_EN is defined, the bench
// also connects max_step_i and runs the rate-limit sequence.

module tb_pid_loop_sequencer;

  logic               clk;
  logic               rst_n;
  logic               enable;
  logic [15:0]        period;
  logic signed [31:0] fb_in;
  logic               fb_valid;
  logic signed [31:0] feedback;
  logic               trig;
  logic               done;
  logic signed [31:0] sig_in;
  logic signed [31:0] out_min;
  logic signed [31:0] out_max;
`ifdef PID_SEQ_RATE_LIMIT_EN
  logic [31:0]        max_step;
`endif
  logic               err_clr;
  logic signed [31:0] act_out;
  logic               act_valid;
  logic               overrun;
  logic               timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // PID responder settings
  logic pid_en;
  int   pid_delay;
  int   cd;

  int trig_cyc[$];
  int act_cyc[$];

  pid_loop_sequencer #(
    .DATA_WIDTH  (32),
    .PERIOD_WIDTH(16),
    .TIMEOUT     (64)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .period_i     (period),
    .fb_in_i      (fb_in),
    .fb_valid_i   (fb_valid),
    .feedback_o   (feedback),
    .trig_o       (trig),
    .done_i       (done),
    .sig_in_i     (sig_in),
    .out_min_i    (out_min),
    .out_max_i    (out_max),
`ifdef PID_SEQ_RATE_LIMIT_EN
    .max_step_i   (max_step),
`endif
    .err_clr_i    (err_clr),
    .act_out_o    (act_out),
    .act_valid_o  (act_valid),
    .overrun_o    (overrun),
    .timeout_err_o(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // The responder raises done pid_delay cycles after it sees trig.
  initial begin
    done = 1'b0;
    cd   = 0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && pid_en) done = 1'b1;
      end
      if (trig) cd = pid_delay;
    end
  end

  always @(negedge clk) begin
    if (trig) trig_cyc.push_back(cyc);
    if (act_valid) act_cyc.push_back(cyc);
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_trig(input int budget, output int t);
    t = -1;
    for (int k = 0; k < budget; k++) begin
      step(1);
      if (trig) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check_eq("wait_trig", trig, 1);
  endtask

  task automatic wait_act(input int budget, output int t);
    t = -1;
    for (int k = 0; k < budget; k++) begin
      step(1);
      if (act_valid) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check_eq("wait_act", act_valid, 1);
  endtask

  initial begin
    int c0, bt, ba, t1, t2, te, ta;
    rst_n     = 1'b0;
    enable    = 1'b0;
    period    = 16'd12;
    fb_in     = 32'sd42;
    fb_valid  = 1'b1;
    sig_in    = 32'sd500;
    out_min   = -32'sd1000;
    out_max   = 32'sd1000;
    err_clr   = 1'b0;
    pid_en    = 1'b1;
    pid_delay = 3;
`ifdef PID_SEQ_RATE_LIMIT_EN
    max_step  = '1;
`endif
    #2;
    check_eq("rst_feedback", feedback, 0);
    check_eq("rst_trig", trig, 0);
    check_eq("rst_act_out", act_out, 0);
    check_eq("rst_act_valid", act_valid, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_timeout_err", timeout_err, 0);
    step(2);
    rst_n = 1'b1;
    step(2);

    // Basic loop: period 12, done 3 cycles after trig.
    bt = trig_cyc.size();
    ba = act_cyc.size();
    c0 = cyc;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) wait_act(60, ta);
    check_eq("basic_first_trig", trig_cyc[bt] - c0, 14);
    check_eq("basic_period_1", trig_cyc[bt+1] - trig_cyc[bt], 12);
    check_eq("basic_period_2", trig_cyc[bt+2] - trig_cyc[bt+1], 12);
    check_eq("basic_act_lat_0", act_cyc[ba] - trig_cyc[bt], 4);
    check_eq("basic_act_lat_2", act_cyc[ba+2] - trig_cyc[bt+2], 4);
    check_eq("basic_act_out", act_out, 500);
    check_eq("basic_feedback", feedback, 42);
    check_eq("basic_n_trig", trig_cyc.size() - bt, 3);
    step(1);
    check_eq("basic_act_valid_pulse", act_valid, 0);

    // Clamp cases.
    sig_in = 32'sd5000;
    wait_act(30, ta);
    check_eq("clamp_max", act_out, 1000);
    sig_in  = -32'sd7000;
    out_min = -32'sd2000;
    wait_act(30, ta);
    check_eq("clamp_min", act_out, -2000);
    out_min = 32'sd10;
    out_max = 32'sd5;
    sig_in  = 32'sd7;
    wait_act(30, ta);
    check_eq("clamp_inverted", act_out, 10);

    // Timeout: no done, so the cycle aborts 65 cycles after trig.
    enable = 1'b0;
    step(3);
    period  = 16'd80;
    pid_en  = 1'b0;
    out_min = -32'sd1000;
    out_max = 32'sd1000;
    sig_in  = 32'sd300;
    ba = act_cyc.size();
    enable = 1'b1;
    wait_trig(120, t1);
    te = -1;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if (timeout_err) begin
        te = cyc;
        break;
      end
    end
    check_eq("to_latency", te - t1, 65);
    check_eq("to_act_out_held", act_out, 10);
    check_eq("to_no_act", act_cyc.size() - ba, 0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check_eq("to_err_clr", timeout_err, 0);
    // Done arriving in the expiry cycle is accepted.
    pid_en    = 1'b1;
    pid_delay = 64;
    wait_trig(100, t2);
    check_eq("to_next_trig", t2 - t1, 80);
    wait_act(80, ta);
    check_eq("to_edge_act_lat", ta - t2, 65);
    check_eq("to_edge_act_out", act_out, 300);
    check_eq("to_edge_no_err", timeout_err, 0);
    enable = 1'b0;
    step(3);

    // Overrun: period 4, done 10 cycles after trig.
    check_eq("ovr_pre", overrun, 0);
    period    = 16'd4;
    pid_delay = 10;
    sig_in    = 32'sd500;
    bt = trig_cyc.size();
    ba = act_cyc.size();
    enable = 1'b1;
    for (int k = 0; k < 3; k++) wait_act(60, ta);
    enable = 1'b0;
    step(5);
    check_eq("ovr_flag", overrun, 1);
    check_eq("ovr_n_trig", trig_cyc.size() - bt, 3);
    check_eq("ovr_n_act", act_cyc.size() - ba, 3);
    for (int i = 0; i < 3; i++) check_eq("ovr_act_lat", act_cyc[ba+i] - trig_cyc[bt+i], 11);
    for (int i = 0; i < 2; i++)
      check_eq("ovr_one_outstanding", trig_cyc[bt+i+1] > act_cyc[ba+i], 1);
    check_eq("ovr_act_out", act_out, 500);

    // Abort: drop enable in WAIT_DONE; the late done must be ignored.
    period    = 16'd12;
    pid_delay = 20;
    bt = trig_cyc.size();
    ba = act_cyc.size();
    enable = 1'b1;
    wait_trig(40, t1);
    step(2);
    enable = 1'b0;
    step(30);
    check_eq("abort_no_act", act_cyc.size() - ba, 0);
    check_eq("abort_n_trig", trig_cyc.size() - bt, 1);
    check_eq("abort_act_out", act_out, 500);
    check_eq("abort_feedback", feedback, 42);

    // Reset in the middle of WAIT_DONE.
    ba = act_cyc.size();
    enable = 1'b1;
    wait_trig(40, t1);
    step(2);
    rst_n = 1'b0;
    #1;
    check_eq("arst_feedback", feedback, 0);
    check_eq("arst_act_out", act_out, 0);
    check_eq("arst_overrun", overrun, 0);
    check_eq("arst_timeout_err", timeout_err, 0);
    check_eq("arst_trig", trig, 0);
    check_eq("arst_act_valid", act_valid, 0);
    step(25);
    check_eq("arst_no_act", act_cyc.size() - ba, 0);
    enable = 1'b0;
    rst_n  = 1'b1;
    step(2);

`ifdef PID_SEQ_RATE_LIMIT_EN
    // Rate limit: step 100 toward 1000, starting from 0.
    max_step  = 32'd100;
    sig_in    = 32'sd1000;
    pid_delay = 3;
    enable    = 1'b1;
    wait_act(40, ta);
    check_eq("rate_1", act_out, 100);
    wait_act(40, ta);
    check_eq("rate_2", act_out, 200);
    wait_act(40, ta);
    check_eq("rate_3", act_out, 300);
    enable = 1'b0;
    step(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pid_loop_sequencer.md
# pid_loop_sequencer

Initiator side of the PID controller's trig/done handshake. Generates the periodic sample tick and captures one sensor sample per period into a held `feedback` register. Fires a single-cycle `trig` into the PID, waits for `done`, then clamps `sig_out` into an actuator command register. Sits between the sensor/ADC front end, the `pid` instance and the actuator driver, replacing the hand-written trigger loop used in simulation.

## Interface
- `DATA_WIDTH`, 32: width of feedback, PID output, actuator command (signed).
- `PERIOD_WIDTH`, 16: width of the sample-period register.
- `TIMEOUT`, 64: cycles allowed from `trig` to `done` before abort.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: loop run; low forces IDLE.
- `period` in PERIOD_WIDTH: sample period in clk cycles, unsigned; 0 is treated as 1.
- `fb_in` in DATA_WIDTH: sensor sample, signed.
- `fb_valid` in 1: `fb_in` valid this cycle.
- `feedback` out DATA_WIDTH: held sample driven to PID `feedback`.
- `trig` out 1: one-cycle calculation request to PID.
- `done` in 1: PID result valid (one-cycle pulse).
- `sig_in` in DATA_WIDTH: PID `sig_out`, signed.
- `out_min`, `out_max` in DATA_WIDTH: signed clamp limits.
- `act_out` out DATA_WIDTH: registered clamped actuator command.
- `act_valid` out 1: one-cycle pulse, `act_out` updated.
- `overrun` out 1: sticky; a tick arrived while a cycle was in flight.
- `timeout_err` out 1: sticky; `done` not seen within TIMEOUT.
- `err_clr` in 1: clears both sticky flags.

## Operation
- FSM states: IDLE, WAIT_TICK, WAIT_SAMPLE, TRIG, WAIT_DONE.
- IDLE: with `enable`=1, load the period counter with max(`period`,1)−1 and go to WAIT_TICK.
- Period counter decrements every cycle outside IDLE. At 0 it emits a tick and reloads from the current `period`.
- WAIT_TICK: on tick, go to WAIT_SAMPLE.
- WAIT_SAMPLE: on `fb_valid`, latch `fb_in` into `feedback` and go to TRIG. Waits indefinitely.
- TRIG: `trig`=1 for exactly this one cycle, then go to WAIT_DONE. Load the timeout counter with TIMEOUT.
- WAIT_DONE: on `done`, set `act_out` = clamp(`sig_in`) and pulse `act_valid`, then go to WAIT_TICK.
- WAIT_DONE timeout: if the counter expires first, set `timeout_err`, leave `act_out` unchanged, and go to WAIT_TICK.
- Clamp uses signed compare: `sig_in` < `out_min` gives `out_min`; else `sig_in` > `out_max` gives `out_max`; else `sig_in`. If `out_min` > `out_max`, the result is `out_min`.
- A tick while in WAIT_SAMPLE, TRIG or WAIT_DONE sets `overrun`. The tick is dropped and the current cycle continues.
- `done` is ignored outside WAIT_DONE. `fb_valid` is ignored outside WAIT_SAMPLE.
- `enable`=0 in any state returns the FSM to IDLE next cycle and aborts any in-flight cycle. `feedback`, `act_out` and the sticky flags hold.
- `err_clr` and a same-cycle error event: the set wins.

## Timing
- Reset values: `feedback`=0, `trig`=0, `act_out`=0, `act_valid`=0, `overrun`=0, `timeout_err`=0, FSM=IDLE.
- First tick: `period` cycles after the first clock edge sampling `enable`=1 in IDLE.
- `fb_valid` high at cycle N in WAIT_SAMPLE gives `feedback` updated at N+1 and `trig` high at N+1.
- `done` high at cycle M in WAIT_DONE gives `act_out`/`act_valid` at M+1.
- Timeout: `done` absent for TIMEOUT cycles after the `trig` cycle gives `timeout_err`=1 on the next cycle.
- `done` arriving in the same cycle as timeout expiry is accepted as done.
- All outputs are registered. No combinational path from input to output.

## Configuration
- `PID_SEQ_RATE_LIMIT_EN` defined: adds input `max_step` [DATA_WIDTH, unsigned].
  - The new command is first clamped, then limited to `act_out` ± `max_step` relative to the previous `act_out`, using saturating signed arithmetic.
- Undefined: no `max_step` port, and the clamp result is written directly.

## Test plan
- Basic loop:
  - Stimulus: reset, `period`=12, `enable`=1, `fb_valid` tied 1, PID model returns `done` 3 cycles after `trig` with `sig_in`=500, limits ±1000.
  - Required response: `trig` every 12 cycles; `act_out`=500 with a single-cycle `act_valid` 4 cycles after each `trig`.
- Clamp:
  - Stimulus: `sig_in`=5000 with `out_max`=1000, then `sig_in`=−7000 with `out_min`=−2000, then `out_min`=10, `out_max`=5.
  - Required response: `act_out` = 1000, then −2000, then 10.
- Timeout:
  - Stimulus: TIMEOUT=64, `done` never returned.
  - Required response: `timeout_err`=1 at 65 cycles after `trig`, `act_out` unchanged, next `trig` one period later. `err_clr` clears the flag.
- Overrun:
  - Stimulus: `period`=4, `done` delayed 10 cycles.
  - Required response: `overrun`=1, exactly one `trig` outstanding at a time, no extra `act_valid`.
- Abort and reset:
  - Stimulus: drop `enable` while in WAIT_DONE, then pulse `done`; separately, assert `reset` low mid-WAIT_DONE.
  - Required response: no `act_valid` in either case; the reset case shows all outputs at reset values asynchronously.
- Rate limit (with `PID_SEQ_RATE_LIMIT_EN` defined):
  - Stimulus: `max_step`=100, `act_out`=0, `sig_in`=1000.
  - Required response: successive `act_out` = 100, 200, 300.
